// File: rtl/io_mmio_bridge.sv
// CPU memory-mapped bridge to a UART: TX FIFO with backpressure, RX read port, stop/halt control.
// Optional cycle counter with coherent 32-bit snapshot, compiled only when IO_CYCLE_COUNTER_EN is defined.
module io_mmio_bridge #(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  io_din,
  output logic        io_buffer_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(TX_DEPTH);
  localparam logic [AW:0]   FULL_LVL_C = (AW+1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [AW:0]   CNT_ZERO_C = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE_C  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO_C = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE_C  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STOP_PEND = 2'd1,
    ST_HALT      = 2'd2
  } state_t;

  logic [7:0]    fifo_mem_r [TX_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          tx_valid_r;
  logic          tx_overflow_r;
  logic [7:0]    io_din_r;
  logic          rx_pop_r;
  logic          program_stop_r;
  state_t        state_r;

  logic       io_sel_s;
  logic       tx_wr_s;
  logic       stop_wr_s;
  logic       rx_rd_s;
  logic       cnt_rd_s;
  logic       pop_s;
  logic       push_req_s;
  logic       push_s;
  logic       drop_s;
  logic [7:0] cnt_byte_s;
  logic       unused_s;

  // Address decode and FIFO push/pop arbitration; a pop frees a slot for a same-cycle push.
  always_comb begin
    io_sel_s   = en && (mem_a[17:16] == 2'b11);
    tx_wr_s    = io_sel_s && mem_wr && (mem_a[15:0] == 16'h0000);
    stop_wr_s  = io_sel_s && mem_wr && (mem_a[15:0] == 16'h0004);
    rx_rd_s    = io_sel_s && !mem_wr && (mem_a[15:0] == 16'h0000);
    cnt_rd_s   = io_sel_s && !mem_wr && (mem_a[15:2] == 14'h0001);
    pop_s      = tx_valid_r && tx_ready;
    push_req_s = tx_wr_s && (mem_dout != 8'h00) && (state_r == ST_RUN);
    push_s     = 1'b0;
    drop_s     = 1'b0;
    if (push_req_s && ((count_r != DEPTH_C) || pop_s)) begin
      push_s = 1'b1;
    end else if (push_req_s) begin
      drop_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE_C;
      2'b01:   count_next_s = count_r - CNT_ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= mem_dout;
    end
  end

  // FIFO pointers, occupancy, valid flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= PTR_ZERO_C;
      rd_ptr_r      <= PTR_ZERO_C;
      count_r       <= CNT_ZERO_C;
      tx_valid_r    <= 1'b0;
      tx_overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r    <= count_next_s;
      tx_valid_r <= (count_next_s != CNT_ZERO_C);
      if (drop_s) begin
        tx_overflow_r <= 1'b1;
      end
    end
  end

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt_r;
  logic [31:0] snapshot_r;
  logic [31:0] snap_view_s;

  // Byte 0 reads the live counter because the snapshot is captured on that same cycle.
  always_comb begin
    snap_view_s = (mem_a[1:0] == 2'b00) ? cycle_cnt_r : snapshot_r;
    case (mem_a[1:0])
      2'b00:   cnt_byte_s = snap_view_s[7:0];
      2'b01:   cnt_byte_s = snap_view_s[15:8];
      2'b10:   cnt_byte_s = snap_view_s[23:16];
      2'b11:   cnt_byte_s = snap_view_s[31:24];
      default: cnt_byte_s = 8'h00;
    endcase
  end

  // Free-running enabled-cycle counter and its snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_r <= 32'h0000_0000;
      snapshot_r  <= 32'h0000_0000;
    end else begin
      if (en) begin
        cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;
      end
      if (cnt_rd_s && (mem_a[1:0] == 2'b00)) begin
        snapshot_r <= cycle_cnt_r;
      end
    end
  end
`else
  assign cnt_byte_s = 8'h00;
`endif

  // Read data register and rx consume pulse; io_din holds when no read is decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_din_r <= 8'h00;
      rx_pop_r <= 1'b0;
    end else begin
      rx_pop_r <= rx_rd_s && rx_valid;
      if (rx_rd_s) begin
        io_din_r <= rx_valid ? rx_data : 8'h00;
      end else if (cnt_rd_s) begin
        io_din_r <= cnt_byte_s;
      end else begin
        io_din_r <= io_din_r;
      end
    end
  end

  // Stop control: after a stop write the FIFO drains, then the bridge halts until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_RUN;
      program_stop_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (stop_wr_s && (count_r == CNT_ZERO_C)) begin
            state_r        <= ST_HALT;
            program_stop_r <= 1'b1;
          end else if (stop_wr_s) begin
            state_r <= ST_STOP_PEND;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_STOP_PEND: begin
          if (count_r == CNT_ZERO_C) begin
            state_r        <= ST_HALT;
            program_stop_r <= 1'b1;
          end else begin
            state_r <= ST_STOP_PEND;
          end
        end
        ST_HALT: begin
          state_r        <= ST_HALT;
          program_stop_r <= 1'b1;
        end
        default: begin
          state_r        <= ST_RUN;
          program_stop_r <= 1'b0;
        end
      endcase
    end
  end

  assign unused_s       = ^{mem_a[31:18], mem_a[1:0]};
  assign tx_data        = fifo_mem_r[rd_ptr_r];
  assign tx_valid       = tx_valid_r;
  assign tx_overflow    = tx_overflow_r;
  assign io_buffer_full = (count_r >= FULL_LVL_C);
  assign io_din         = io_din_r;
  assign rx_pop         = rx_pop_r;
  assign program_stop   = program_stop_r;

endmodule

// File: tb/tb_io_mmio_bridge.sv
// Self-checking bench for io_mmio_bridge: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_io_mmio_bridge;
  localparam int TX_DEPTH    = 16;
  localparam int FULL_MARGIN = 2;

  logic        clk = 1'b0;
  logic        rst, en, mem_wr, rx_valid, tx_ready;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, rx_data;
  logic [7:0]  io_din, tx_data;
  logic        io_buffer_full, rx_pop, tx_valid, program_stop, tx_overflow;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  byte unsigned m_q[$];
  bit           m_ovf, m_pend, m_halt, m_pop;
  logic [7:0]   m_din;
  int unsigned  m_cyc, m_snap;

  io_mmio_bridge #(.TX_DEPTH(TX_DEPTH), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .io_din(io_din), .io_buffer_full(io_buffer_full), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_pop(rx_pop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .program_stop(program_stop), .tx_overflow(tx_overflow));

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a = a; mem_wr = wr; mem_dout = d;
  endtask

  // One clock edge: applies current inputs to both DUT and model, returns 1 time unit after the edge.
  task automatic step();
    bit io, wr0, wr4, rd0, rdc, pop, rst_v, rxv, en_v;
    int qs0;
    logic [7:0] d, rxd;
    logic [1:0] bsel;
    io    = en && (mem_a[17:16] == 2'b11);
    wr0   = io && mem_wr && (mem_a[15:0] == 16'h0000);
    wr4   = io && mem_wr && (mem_a[15:0] == 16'h0004);
    rd0   = io && !mem_wr && (mem_a[15:0] == 16'h0000);
    rdc   = io && !mem_wr && (mem_a[15:0] >= 16'h0004) && (mem_a[15:0] <= 16'h0007);
    bsel  = mem_a[1:0];
    pop   = (m_q.size() != 0) && tx_ready;
    rst_v = rst; d = mem_dout; rxd = rx_data; rxv = rx_valid; en_v = en;
    qs0   = m_q.size();
    @(posedge clk);
    if (rst_v) begin
      m_q.delete(); m_ovf = 0; m_pend = 0; m_halt = 0; m_pop = 0;
      m_din = 8'h00; m_cyc = 0; m_snap = 0;
    end else begin
      if (m_pend && qs0 == 0) m_halt = 1;
      if (pop) void'(m_q.pop_front());
      if (wr0 && d != 8'h00 && !m_pend) begin
        if (m_q.size() < TX_DEPTH) m_q.push_back(d);
        else m_ovf = 1;
      end
      if (wr4 && !m_pend) begin
        m_pend = 1;
        if (qs0 == 0) m_halt = 1;
      end
      m_pop = rd0 && rxv;
      if (rd0) m_din = rxv ? rxd : 8'h00;
      if (rdc) begin
        if (bsel == 2'd0) m_snap = m_cyc;
`ifdef IO_CYCLE_COUNTER_EN
        m_din = 8'((m_snap / (32'd1 << (8 * bsel))) % 32'd256);
`else
        m_din = 8'h00;
`endif
      end
      if (en_v) m_cyc = m_cyc + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    drive(32'h0, 1'b0, 8'h00);
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %0b want 0", tx_valid); end
    n_vec++; if (io_din !== 8'h00) begin n_err++; $display("FAIL reset_io_din got %h want 00", io_din); end
    n_vec++; if (rx_pop !== 1'b0) begin n_err++; $display("FAIL reset_rx_pop got %0b want 0", rx_pop); end
    n_vec++; if (io_buffer_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", io_buffer_full); end
    n_vec++; if ({program_stop, tx_overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {program_stop, tx_overflow}); end
  endtask

  task automatic test_hello();
    do_reset();
    tx_ready = 1'b1;
    drive(32'h0003_0000, 1'b1, 8'h48); step();
    n_vec++; if ({tx_valid, tx_data} !== {1'b1, 8'h48}) begin n_err++; $display("FAIL hello_first got %0b/%h want 1/48", tx_valid, tx_data); end
    drive(32'h0003_0000, 1'b1, 8'h69); step();
    n_vec++; if ({tx_valid, tx_data} !== {1'b1, 8'h69}) begin n_err++; $display("FAIL hello_second got %0b/%h want 1/69", tx_valid, tx_data); end
    drive(32'h0, 1'b0, 8'h00); step();
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL hello_drained got %0b want 0", tx_valid); end
  endtask

  task automatic test_zero_write();
    do_reset();
    drive(32'h0003_0000, 1'b1, 8'h00); step();
    drive(32'h0, 1'b0, 8'h00);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL zero_write_valid got %0b want 0", tx_valid); end
    tx_ready = 1'b1; drive(32'h0003_0000, 1'b1, 8'h33); step(); drive(32'h0, 1'b0, 8'h00);
    n_vec++; if ({tx_valid, tx_data} !== {1'b1, 8'h33}) begin n_err++; $display("FAIL zero_write_count got %0b/%h want 1/33", tx_valid, tx_data); end
  endtask

  task automatic test_fill_overflow();
    byte unsigned sent[$];
    logic [7:0] b;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      b = 8'($urandom_range(1, 255));
      if (i <= TX_DEPTH) sent.push_back(b);
      drive(32'h0003_0000, 1'b1, b); step();
      if (i == 13) begin
        n_vec++; if (io_buffer_full !== 1'b0) begin n_err++; $display("FAIL fill_13_full got %0b want 0", io_buffer_full); end
      end
      if (i == 14) begin
        n_vec++; if (io_buffer_full !== 1'b1) begin n_err++; $display("FAIL fill_14_full got %0b want 1", io_buffer_full); end
      end
      if (i == 16) begin
        n_vec++; if (tx_overflow !== 1'b0) begin n_err++; $display("FAIL fill_16_ovf got %0b want 0", tx_overflow); end
      end
    end
    drive(32'h0, 1'b0, 8'h00);
    n_vec++; if (tx_overflow !== 1'b1) begin n_err++; $display("FAIL fill_17_ovf got %0b want 1", tx_overflow); end
    tx_ready = 1'b1;
    for (int i = 0; i < TX_DEPTH; i++) begin
      n_vec++; if ({tx_valid, tx_data} !== {1'b1, sent[i]}) begin n_err++; $display("FAIL fill_order[%0d] got %0b/%h want 1/%h", i, tx_valid, tx_data, sent[i]); end
      step();
    end
    n_vec++; if ({tx_valid, tx_overflow} !== 2'b01) begin n_err++; $display("FAIL fill_end got valid/ovf %b want 01", {tx_valid, tx_overflow}); end
  endtask

  task automatic test_counter();
    logic [7:0] exp_b[4];
`ifdef IO_CYCLE_COUNTER_EN
    exp_b[0] = 8'hE7; exp_b[1] = 8'h03; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
`else
    exp_b[0] = 8'h00; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
`endif
    do_reset();
    for (int i = 0; i < 999; i++) step();
    for (int k = 0; k < 4; k++) begin
      drive(32'h0003_0004 + 32'(k), 1'b0, 8'h00); step();
      drive(32'h0, 1'b0, 8'h00);
      n_vec++; if (io_din !== exp_b[k]) begin n_err++; $display("FAIL counter_byte%0d got %h want %h", k, io_din, exp_b[k]); end
      en = 1'b0; step(); step(); en = 1'b1; step();
      n_vec++; if (io_din !== exp_b[k]) begin n_err++; $display("FAIL counter_hold%0d got %h want %h", k, io_din, exp_b[k]); end
    end
    drive(32'h0003_0004, 1'b0, 8'h00); step(); drive(32'h0, 1'b0, 8'h00);
    n_vec++; if (io_din !== m_din) begin n_err++; $display("FAIL counter_reread got %h want %h", io_din, m_din); end
  endtask

  task automatic test_rx();
    logic [7:0] v;
    do_reset();
    v = 8'($urandom_range(1, 255));
    rx_valid = 1'b1; rx_data = v;
    drive(32'h0003_0000, 1'b0, 8'h00); step(); drive(32'h0, 1'b0, 8'h00);
    n_vec++; if ({rx_pop, io_din} !== {1'b1, v}) begin n_err++; $display("FAIL rx_read got %0b/%h want 1/%h", rx_pop, io_din, v); end
    step();
    n_vec++; if ({rx_pop, io_din} !== {1'b0, v}) begin n_err++; $display("FAIL rx_hold got %0b/%h want 0/%h", rx_pop, io_din, v); end
    en = 1'b0; drive(32'h0003_0000, 1'b0, 8'h00); step(); en = 1'b1;
    drive(32'h0002_0000, 1'b0, 8'h00); step();
    n_vec++; if ({rx_pop, io_din} !== {1'b0, v}) begin n_err++; $display("FAIL rx_nodecode got %0b/%h want 0/%h", rx_pop, io_din, v); end
    rx_valid = 1'b0;
    drive(32'h0003_0000, 1'b0, 8'h00); step(); drive(32'h0, 1'b0, 8'h00);
    n_vec++; if ({rx_pop, io_din} !== {1'b0, 8'h00}) begin n_err++; $display("FAIL rx_empty got %0b/%h want 0/00", rx_pop, io_din); end
  endtask

  task automatic test_stop();
    byte unsigned sent[3];
    int waited;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sent[i] = 8'($urandom_range(1, 255));
      drive(32'h0003_0000, 1'b1, sent[i]); step();
    end
    drive(32'h0003_0004, 1'b1, 8'h00); step();
    n_vec++; if (program_stop !== 1'b0) begin n_err++; $display("FAIL stop_pending got %0b want 0", program_stop); end
    drive(32'h0003_0000, 1'b1, 8'h41); step(); drive(32'h0, 1'b0, 8'h00);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({tx_valid, tx_data, program_stop} !== {1'b1, sent[i], 1'b0}) begin n_err++; $display("FAIL stop_drain[%0d] got %0b/%h/%0b want 1/%h/0", i, tx_valid, tx_data, program_stop, sent[i]); end
      step();
    end
    waited = 0;
    while (program_stop !== 1'b1 && waited < 4) begin step(); waited++; end
    n_vec++; if (program_stop !== 1'b1) begin n_err++; $display("FAIL stop_halt got %0b want 1 after %0d cycles", program_stop, waited); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL stop_no41 got valid %0b data %h want 0", tx_valid, tx_data); end
    do_reset();
    drive(32'h0003_0004, 1'b1, 8'h00); step();
    n_vec++; if (program_stop !== 1'b1) begin n_err++; $display("FAIL stop_direct got %0b want 1", program_stop); end
    drive(32'h0003_0000, 1'b1, 8'h41); step(); drive(32'h0, 1'b0, 8'h00);
    n_vec++; if ({tx_valid, program_stop} !== 2'b01) begin n_err++; $display("FAIL stop_halted_push got %b want 01", {tx_valid, program_stop}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(32'h0003_0000, 1'b1, 8'($urandom_range(1, 255))); step(); end
    drive(32'h0, 1'b0, 8'h00); tx_ready = 1'b1; step();
    rst = 1'b1; step(); rst = 1'b0;
    n_vec++; if ({tx_valid, io_buffer_full, program_stop} !== 3'b000) begin n_err++; $display("FAIL rstmid got %b want 000", {tx_valid, io_buffer_full, program_stop}); end
    drive(32'h0003_0000, 1'b1, 8'h5A); step(); drive(32'h0, 1'b0, 8'h00);
    n_vec++; if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL rstmid_run got %0b/%h want 1/5a", tx_valid, tx_data); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 7);
      en = ($urandom_range(0, 7) != 0);
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data = 8'($urandom);
      case (r)
        0, 1, 2: drive({14'($urandom), 18'h3_0000}, 1'b1, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        3:       drive(32'h0003_0000, 1'b0, 8'($urandom));
        4:       drive(32'h0003_0004 + 32'($urandom_range(0, 3)), 1'b0, 8'h00);
        5:       drive(32'h0002_0000, 1'b1, 8'($urandom_range(1, 255)));
        6:       drive(32'h0003_0008, 1'b0, 8'h00);
        default: drive(32'h0, 1'b0, 8'h00);
      endcase
      step();
      n_vec++; if (tx_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid c%0d got %0b want %0b", c, tx_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        n_vec++; if (tx_data !== m_q[0]) begin n_err++; $display("FAIL rnd_data c%0d got %h want %h", c, tx_data, m_q[0]); end
      end
      n_vec++; if (io_buffer_full !== (m_q.size() >= TX_DEPTH - FULL_MARGIN)) begin n_err++; $display("FAIL rnd_full c%0d got %0b size %0d", c, io_buffer_full, m_q.size()); end
      n_vec++; if (io_din !== m_din) begin n_err++; $display("FAIL rnd_din c%0d got %h want %h", c, io_din, m_din); end
      n_vec++; if (rx_pop !== m_pop) begin n_err++; $display("FAIL rnd_rxpop c%0d got %0b want %0b", c, rx_pop, m_pop); end
      n_vec++; if (tx_overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf c%0d got %0b want %0b", c, tx_overflow, m_ovf); end
      n_vec++; if (program_stop !== m_halt) begin n_err++; $display("FAIL rnd_stop c%0d got %0b want %0b", c, program_stop, m_halt); end
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_zero_write();
    test_fill_overflow();
    test_counter();
    test_rx();
    test_stop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/io_mmio_bridge.md
IO_MMIO_BRIDGE -- requirements
Module: io_mmio_bridge

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 16, TX FIFO entries (power of two, >=4).
REQ-002 SHALL have parameter FULL_MARGIN, default 2, free entries remaining when io_buffer_full asserts.
REQ-003 SHALL have ports: clk  in  1  system clock; rst  in  1  reset, synchronous, active-high; en  in  1  CPU-side enable, pause when low.
REQ-004 SHALL have ports: mem_a  in  32  CPU address bus; mem_wr  in  1  1=write; mem_dout  in  8  CPU write data.
REQ-005 SHALL have ports: io_din  out  8  read data to CPU; io_buffer_full  out  1  backpressure to CPU.
REQ-006 SHALL have ports: rx_data  in  8  UART rx byte; rx_valid  in  1  rx byte present; rx_pop  out  1  one-cycle rx consume pulse.
REQ-007 SHALL have ports: tx_data  out  8  UART tx byte; tx_valid  out  1  FIFO non-empty; tx_ready  in  1  UART accepts byte.
REQ-008 SHALL have ports: program_stop  out  1  sticky halt; tx_overflow  out  1  sticky drop flag.

Function
REQ-009 SHALL decode an IO access only when en=1 and mem_a[17:16]=2'b11; other addresses SHALL leave all state unchanged.
REQ-010 SHALL push mem_dout into TX FIFO on write to 0x30000 when mem_dout!=0; writes of 0x00 SHALL be ignored.
REQ-011 SHALL make a pushed byte visible on tx_data/tx_valid the cycle after the write (1-cycle latency).
REQ-012 SHALL pop the FIFO head when tx_valid=1 and tx_ready=1, independent of en.
REQ-013 SHALL keep count unchanged on simultaneous push and pop, including when full (pop frees slot same cycle).
REQ-014 SHALL drop a push arriving with count=TX_DEPTH and no concurrent pop, and set tx_overflow sticky.
REQ-015 SHALL assert io_buffer_full combinationally from registered count when count >= TX_DEPTH-FULL_MARGIN.
REQ-016 SHALL wrap read/write pointers modulo TX_DEPTH; count SHALL be log2(TX_DEPTH)+1 bits.
REQ-017 SHALL, on read of 0x30000, drive io_din=rx_data next cycle (0x00 if rx_valid=0) and pulse rx_pop for one cycle only if rx_valid=1.
REQ-018 SHALL, on read of 0x30004..0x30007, drive io_din next cycle with byte mem_a[1:0] of the cycle-counter snapshot (little-endian).
REQ-019 SHALL capture the snapshot on read of 0x30004 so bytes 1..3 read later are coherent with byte 0.
REQ-020 SHALL increment the 32-bit cycle counter every cycle en=1, wrapping 0xFFFFFFFF->0; frozen when en=0.
REQ-021 SHALL hold io_din at its last value on cycles with no IO read.
REQ-022 SHALL, on write to 0x30004, enter STOP_PEND: further tx pushes ignored; FIFO keeps draining.
REQ-023 SHALL implement states RUN -> STOP_PEND (stop write) -> HALT (FIFO empty); HALT asserts program_stop; only rst exits HALT.
REQ-024 SHALL go RUN directly to HALT next cycle if stop write occurs with FIFO empty and no push.

Reset
REQ-025 SHALL on rst: FIFO empty, pointers/count 0, tx_valid=0, io_din=0, rx_pop=0, counter=0, snapshot=0, state RUN, program_stop=0, tx_overflow=0.
REQ-026 SHALL discard FIFO contents on rst asserted mid-drain; tx_valid SHALL be 0 the cycle after rst.

Configuration
REQ-027 SHALL compile cycle counter and snapshot only when IO_CYCLE_COUNTER_EN is defined.
REQ-028 SHALL, without IO_CYCLE_COUNTER_EN, return io_din=0x00 for reads of 0x30004..0x30007; all other behaviour unchanged.

Verification
REQ-029 SHALL cover: writes 0x48,0x69 to 0x30000, tx_ready=1 -> tx_data 0x48 then 0x69, one cycle after each write.
REQ-030 SHALL cover: tx_ready=0, 14 writes (depth 16) -> io_buffer_full=1 after 14th; 17th write -> tx_overflow=1, 16 bytes preserved in order.
REQ-031 SHALL cover: write 0x00 to 0x30000 -> tx_valid stays 0, count 0.
REQ-032 SHALL cover: en=1 for 1000 cycles after reset, read 0x30004..0x30007 -> bytes form snapshot value 999 at byte-0 read (IO_CYCLE_COUNTER_EN defined); 0x00 each without it.
REQ-033 SHALL cover: 3 bytes queued, tx_ready=0, write to 0x30004 -> program_stop=0 until 3 pops, then 1; later write 0x41 not emitted.
REQ-034 SHALL cover: rst asserted with 5 bytes queued -> tx_valid=0, io_buffer_full=0 next cycle, state RUN.
